// File: rtl/eval_pkg.sv
// eval_pkg: shared widths, ROM contents and lookup helper for eval_pipeline.
package eval_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned ADDR_W_DEF = 4;
   localparam int unsigned ROM_N      = 7;

   localparam logic [7:0] ROM_VALS [ROM_N] = '{8'd57, 8'd61, 8'd22, 8'd98, 8'd121, 8'd17, 8'd13};
   localparam logic [7:0] ROM_FILL = 8'd3;

   // Table value for the first ROM_N addresses, fill value everywhere else.
   function automatic logic [7:0] rom_lookup(input int unsigned addr);
      logic [7:0] val;
      val = ROM_FILL;
      for (int unsigned i = 0; i < ROM_N; i++) begin
         if (addr == i) val = ROM_VALS[3'(i)];
      end
      return val;
   endfunction

endpackage

// File: rtl/eval_rom.sv
// eval_rom: registered-read constant ROM, depth 2^ADDR_W, zero-extended to DATA_W.
module eval_rom
   import eval_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   // Read register; holds its value when load is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
      end else if (load) begin
         data <= DATA_W'(rom_lookup(32'(addr)));
      end
   end

endmodule

// File: rtl/eval_pipeline.sv
// eval_pipeline: three-stage valid/ready pipeline computing
//   result = (kernel_enable ? rom[data_in1] : 0) + ~data_in2 + data_in1  (mod 2^DATA_W).
// Optional macro EVAL_GATE_EN: stage data registers load only for valid items
// (and the ROM read only when kernel_enable=1), so result holds across bubbles.
module eval_pipeline
   import eval_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in1,
   input  logic [DATA_W-1:0] data_in2,
   input  logic              kernel_enable,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result
);

   logic              advance;
   logic              ld1;
   logic              ld2;
   logic              ld3;
   logic              rom_ld;

   logic              v1;
   logic [DATA_W-1:0] a1;
   logic [DATA_W-1:0] f1;
   logic              k1;
   logic [DATA_W-1:0] r1;

   logic              v2;
   logic [DATA_W-1:0] s2;
   logic              k2;
   logic [DATA_W-1:0] r2;

   // Whole pipeline moves together; it only stalls when a held result is refused.
   assign advance  = out_ready | ~out_valid;
   assign in_ready = advance;

`ifdef EVAL_GATE_EN
   // Data registers load only when a valid item enters the stage.
   assign ld1    = advance & in_valid;
   assign ld2    = advance & v1;
   assign ld3    = advance & v2;
   assign rom_ld = ld1 & kernel_enable;
`else
   // Data registers follow every advance, bubbles included.
   assign ld1    = advance;
   assign ld2    = advance;
   assign ld3    = advance;
   assign rom_ld = advance;
`endif

   // Valid bits shift on advance and freeze while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
      end else if (advance) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
      end
   end

   // S1 ROM term is registered inside the ROM itself.
   eval_rom #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rom (
      .clk  (clk),
      .rst  (rst),
      .load (rom_ld),
      .addr (data_in1[ADDR_W-1:0]),
      .data (r1)
   );

   // S1: capture addend, inverted operand and kernel select.
   always_ff @(posedge clk) begin
      if (rst) begin
         a1 <= '0;
         f1 <= '0;
         k1 <= 1'b0;
      end else if (ld1) begin
         a1 <= data_in1;
         f1 <= ~data_in2;
         k1 <= kernel_enable;
      end
   end

   // S2: partial sum and forwarding of the ROM term.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2 <= '0;
         k2 <= 1'b0;
         r2 <= '0;
      end else if (ld2) begin
         s2 <= a1 + f1;
         k2 <= k1;
         r2 <= r1;
      end
   end

   // S3: optional ROM add into the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
      end else if (ld3) begin
         result <= k2 ? (s2 + r2) : s2;
      end
   end

endmodule
